pc_sequencer: RTL and testbench

//   Next-PC / branch-resolution stage. Sits directly downstream of branch_comparator.

---
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 tb/tb_pc_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC / branch-resolution stage: owns the program counter, resolves jumps,
// calls and returns against a return-address stack, and drives the fetch flush.
package pc_seq_pkg;
    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_JMP  = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_JEQ  = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_JNE  = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_JLT  = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_JGE  = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_CALL = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_RET  = 4'h8;
endpackage

module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                WORD_W       = 16,
    parameter logic [WORD_W-1:0] RESET_PC     = '0,
    parameter logic [WORD_W-1:0] PC_STEP      = WORD_W'(1),
    parameter int                FLUSH_CYCLES = 2,
    parameter int                RAS_DEPTH    = 4,
    localparam int               RAS_W        = $clog2(RAS_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [WORD_W-1:0]   target,
    input  logic                zero,
    input  logic                is_less_than,
    output logic [WORD_W-1:0]   pc,
    output logic                flush,
    output logic                fault,
    output logic [RAS_W-1:0]    ras_count
);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] pc_d;
    logic              flush_d, fault_d;
    logic [RAS_W-1:0]  count_d;
    logic [WORD_W-1:0] seq_pc;
    logic              take, push;
    logic              is_call, is_ret, ras_full, ras_empty;
    logic [IDX_W-1:0]  push_idx, top_idx;
    logic [WORD_W-1:0] stack [RAS_DEPTH];

    assign seq_pc    = pc + PC_STEP;
    assign is_call   = instr_valid && (opcode == OP_CALL);
    assign is_ret    = instr_valid && (opcode == OP_RET);
    assign ras_full  = (ras_count == RAS_W'(RAS_DEPTH));
    assign ras_empty = (ras_count == '0);
    assign push_idx  = IDX_W'(ras_count);
    assign top_idx   = IDX_W'(ras_count - RAS_W'(1));

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        cnt_d   = cnt_q;
        flush_d = flush;
        fault_d = fault;
        count_d = ras_count;
        push    = 1'b0;
        take    = 1'b0;

        if (instr_valid) begin
            case (opcode)
                OP_JMP, OP_CALL, OP_RET: take = 1'b1;
                OP_JEQ:                  take = zero;
                OP_JNE:                  take = !zero;
                OP_JLT:                  take = is_less_than;
                OP_JGE:                  take = !is_less_than;
                default:                 take = 1'b0;
            endcase
        end

        case (state_q)
            ST_RUN: begin
                if ((is_call && ras_full) || (is_ret && ras_empty)) begin
                    // Stack misuse locks the sequencer until reset, pc stays put.
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    flush_d = 1'b1;
                end else if (take) begin
                    pc_d    = is_ret ? stack[top_idx] : target;
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    flush_d = 1'b1;
                    if (is_call) begin
                        push    = 1'b1;
                        count_d = ras_count + RAS_W'(1);
                    end else if (is_ret) begin
                        count_d = ras_count - RAS_W'(1);
                    end
                end else begin
                    pc_d    = seq_pc;
                    flush_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                // Wrong-path instructions are ignored; fetch keeps streaming.
                pc_d = seq_pc;
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    flush_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FAULT: begin
                flush_d = 1'b1;
                fault_d = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            pc        <= RESET_PC;
            cnt_q     <= '0;
            flush     <= 1'b0;
            fault     <= 1'b0;
            ras_count <= '0;
        end else if (!stall) begin
            state_q   <= state_d;
            pc        <= pc_d;
            cnt_q     <= cnt_d;
            flush     <= flush_d;
            fault     <= fault_d;
            ras_count <= count_d;
        end
    end

    // NOTE: stack storage has no reset; entries are only read below ras_count, which is reset.
    always_ff @(posedge clk) begin
        if (!stall && push) begin
            stack[push_idx] <= seq_pc;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int          FLUSH_CYCLES = 2;
    localparam int          RAS_DEPTH    = 4;
    localparam int          RAS_W        = $clog2(RAS_DEPTH + 1);
    localparam logic [15:0] RESET_PC     = 16'h0000;
    localparam logic [15:0] PC_STEP      = 16'h0001;

    logic             clk          = 1'b0;
    logic             reset        = 1'b0;
    logic             stall        = 1'b0;
    logic             instr_valid  = 1'b0;
    logic [3:0]       opcode       = 4'h0;
    logic [15:0]      target       = 16'h0;
    logic             zero         = 1'b0;
    logic             is_less_than = 1'b0;
    logic [15:0]      pc;
    logic             flush;
    logic             fault;
    logic [RAS_W-1:0] ras_count;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Behavioural model: pc, remaining flush cycles, sticky fault, return stack.
    logic [15:0] m_pc;
    int          m_flush_rem;
    bit          m_fault;
    logic [15:0] m_stack [$];

    always #5 clk = ~clk;

    pc_sequencer #(
        .WORD_W      (16),
        .RESET_PC    (RESET_PC),
        .PC_STEP     (PC_STEP),
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .RAS_DEPTH   (RAS_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .target      (target),
        .zero        (zero),
        .is_less_than(is_less_than),
        .pc          (pc),
        .flush       (flush),
        .fault       (fault),
        .ras_count   (ras_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc        = RESET_PC;
        m_flush_rem = 0;
        m_fault     = 1'b0;
        m_stack.delete();
    endtask

    task automatic m_redirect(input logic [15:0] t);
        m_pc        = t;
        m_flush_rem = FLUSH_CYCLES;
    endtask

    task automatic model_step();
        if (!reset) begin
            model_reset();
            return;
        end
        if (stall || m_fault) return;
        if (m_flush_rem > 0) begin
            m_pc = m_pc + PC_STEP;
            m_flush_rem--;
            return;
        end
        if (!instr_valid) begin
            m_pc = m_pc + PC_STEP;
            return;
        end
        case (opcode)
            OP_JMP: m_redirect(target);
            OP_JEQ: if (zero) m_redirect(target); else m_pc = m_pc + PC_STEP;
            OP_JNE: if (!zero) m_redirect(target); else m_pc = m_pc + PC_STEP;
            OP_JLT: if (is_less_than) m_redirect(target); else m_pc = m_pc + PC_STEP;
            OP_JGE: if (!is_less_than) m_redirect(target); else m_pc = m_pc + PC_STEP;
            OP_CALL: begin
                if (m_stack.size() == RAS_DEPTH) begin
                    m_fault = 1'b1;
                end else begin
                    m_stack.push_back(m_pc + PC_STEP);
                    m_redirect(target);
                end
            end
            OP_RET: begin
                if (m_stack.size() == 0) m_fault = 1'b1;
                else m_redirect(m_stack.pop_back());
            end
            default: m_pc = m_pc + PC_STEP;
        endcase
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("pc", 32'(pc), 32'(m_pc));
            check("flush", 32'(flush), 32'(m_fault || (m_flush_rem > 0)));
            check("fault", 32'(fault), 32'(m_fault));
            check("ras_count", 32'(ras_count), 32'(m_stack.size()));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] o, input logic [15:0] t);
        instr_valid = 1'b1;
        opcode      = o;
        target      = t;
        tick();
        instr_valid = 1'b0;
        opcode      = 4'h0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        #1;
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        #1;
        check("reset_pc", 32'(pc), 32'h0);
        check("reset_flush", 32'(flush), 32'h0);
        check("reset_fault", 32'(fault), 32'h0);
        check("reset_count", 32'(ras_count), 32'h0);
        reset    = 1'b1;
        check_en = 1'b1;

        // Sequential fetch
        repeat (4) tick();
        check("seq_pc4", 32'(pc), 32'h4);
        check("seq_flush", 32'(flush), 32'h0);
        tick();

        // JEQ taken at pc=5, then not taken
        zero = 1'b1;
        op(OP_JEQ, 16'h0040);
        check("jeq_pc", 32'(pc), 32'h40);
        check("jeq_flush", 32'(flush), 32'h1);
        tick();
        check("jeq_flush_pc1", 32'(pc), 32'h41);
        check("jeq_flush2", 32'(flush), 32'h1);
        tick();
        check("jeq_after_flush", 32'(flush), 32'h0);
        zero = 1'b0;
        op(OP_JEQ, 16'h0050);
        check("jeq_nt_pc", 32'(pc), 32'h43);
        check("jeq_nt_flush", 32'(flush), 32'h0);

        // JLT during flush is wrong-path
        op(OP_JMP, 16'h0080);
        is_less_than = 1'b1;
        op(OP_JLT, 16'h0200);
        check("jlt_ignored", 32'(pc), 32'h81);
        is_less_than = 1'b0;
        tick();
        check("jlt_ignored2", 32'(pc), 32'h82);

        // CALL then RET
        op(OP_JMP, 16'h000E);
        tick();
        tick();
        check("pre_call_pc", 32'(pc), 32'h10);
        op(OP_CALL, 16'h0100);
        check("call_pc", 32'(pc), 32'h100);
        check("call_count", 32'(ras_count), 32'h1);
        tick();
        tick();
        op(OP_RET, 16'h0000);
        check("ret_pc", 32'(pc), 32'h11);
        check("ret_count", 32'(ras_count), 32'h0);
        tick();
        tick();

        // Stack overflow
        pulse_reset();
        for (int k = 1; k <= RAS_DEPTH + 1; k++) begin
            op(OP_CALL, 16'(k * 32));
            if (k <= RAS_DEPTH) begin
                tick();
                tick();
            end
        end
        check("ovf_fault", 32'(fault), 32'h1);
        check("ovf_pc", 32'(pc), 32'h82);
        check("ovf_count", 32'(ras_count), 32'h4);
        tick();
        tick();
        check("ovf_pc_frozen", 32'(pc), 32'h82);
        check("ovf_flush", 32'(flush), 32'h1);

        // Stack underflow
        pulse_reset();
        op(OP_RET, 16'h0000);
        check("unf_fault", 32'(fault), 32'h1);
        check("unf_pc", 32'(pc), 32'h0);
        pulse_reset();

        // Stall mid-flush
        op(OP_JMP, 16'h0300);
        stall = 1'b1;
        repeat (3) tick();
        check("stall_pc", 32'(pc), 32'h300);
        check("stall_flush", 32'(flush), 32'h1);
        stall = 1'b0;
        tick();
        check("stall_flush_more", 32'(flush), 32'h1);
        tick();
        check("stall_flush_end", 32'(flush), 32'h0);
        check("stall_pc_end", 32'(pc), 32'h302);

        // Async reset mid-flush
        op(OP_JMP, 16'h0400);
        reset = 1'b0;
        model_reset();
        #1;
        check("async_rst_pc", 32'(pc), 32'h0);
        check("async_rst_flush", 32'(flush), 32'h0);
        #1;
        reset = 1'b1;

        // Wrap-around
        op(OP_JMP, 16'hFFFD);
        tick();
        tick();
        check("wrap_pre", 32'(pc), 32'hFFFF);
        tick();
        check("wrap_pc", 32'(pc), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 399) == 0) begin
                reset = 1'b0;
                model_reset();
            end else begin
                reset = 1'b1;
            end
            stall        = ($urandom_range(0, 9) == 0);
            instr_valid  = ($urandom_range(0, 3) != 0);
            opcode       = 4'($urandom_range(0, 10));
            target       = 16'($urandom);
            zero         = 1'($urandom);
            is_less_than = 1'($urandom);
            tick();
        end

        reset       = 1'b1;
        stall       = 1'b0;
        instr_valid = 1'b0;
        repeat (4) tick();
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
